// File: rtl/uart_wb_bridge.sv
// rtl/uart_wb_bridge.sv - UART byte-stream to Wishbone single-access debug bridge
module uart_wb_bridge #(
  parameter int wb_timeout = 1024,
  parameter int rx_timeout = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        active
);
  localparam int wb_cnt_w = $clog2(wb_timeout + 1);
  localparam int rx_cnt_w = $clog2(rx_timeout + 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, TX, TX_WAIT} state_t;

  state_t              state;
  logic [1:0]          cnt;
  logic                is_write;
  logic                err;
  logic                guard;
  logic [rx_cnt_w-1:0] idle_cnt;
  logic [wb_cnt_w-1:0] bus_cnt;
  logic [31:0]         tx_shift;
  logic [1:0]          tx_left;
  logic                take;

  // rx_ack is the registered copy of take, so a byte can never be taken twice in a row
  assign take   = rx_avail && !rx_ack && (state == IDLE || state == ADDR || state == DATA);
  assign active = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_write <= 1'b0;
      err      <= 1'b0;
      guard    <= 1'b0;
      idle_cnt <= '0;
      bus_cnt  <= '0;
      tx_shift <= '0;
      tx_left  <= '0;
      rx_ack   <= 1'b0;
      tx_data  <= '0;
      tx_wr    <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
    end else begin
      rx_ack <= take;
      tx_wr  <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            idle_cnt <= '0;
            cnt      <= '0;
            if (rx_data == 8'h72 || rx_data == 8'h77) begin
              is_write <= (rx_data == 8'h77);
              state    <= ADDR;
            end
          end
        end
        ADDR, DATA: begin
          if (take) begin
            idle_cnt <= '0;
            cnt      <= cnt + 2'd1;
            if (state == ADDR) wb_adr_o <= {wb_adr_o[23:0], rx_data};
            else               wb_dat_o <= {wb_dat_o[23:0], rx_data};
            if (cnt == 2'd3) begin
              if (state == ADDR && is_write) begin
                state <= DATA;
              end else begin
                state    <= BUS;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_sel_o <= 4'hF;
                wb_we_o  <= is_write;
                bus_cnt  <= '0;
              end
            end
          end else if (idle_cnt == rx_cnt_w'(rx_timeout - 1)) begin
            state <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        BUS: begin
          // ack is checked before the timeout so a last-cycle ack still succeeds
          if (wb_ack_i || bus_cnt == wb_cnt_w'(wb_timeout - 1)) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            err      <= !wb_ack_i;
            state    <= TX;
            if (wb_ack_i && !is_write) begin
              tx_shift <= wb_dat_i;
              tx_left  <= 2'd3;
            end else begin
              tx_shift <= {8'h4B, 24'h0};
              tx_left  <= 2'd0;
            end
          end else begin
            bus_cnt <= bus_cnt + 1'b1;
          end
        end
        TX: begin
          if (!tx_busy) begin
            tx_data  <= err ? 8'h45 : tx_shift[31:24];
            tx_wr    <= 1'b1;
            tx_shift <= {tx_shift[23:0], 8'h00};
            guard    <= 1'b1;
            state    <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          // guard cycle lets the transmitter raise tx_busy for the byte just written
          if (guard) begin
            guard <= 1'b0;
          end else if (!tx_busy) begin
            if (tx_left == 2'd0) begin
              state <= IDLE;
            end else begin
              tx_left <= tx_left - 2'd1;
              state   <= TX;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb/tb_uart_wb_bridge.sv - randomized self-checking bench for uart_wb_bridge
module tb_uart_wb_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_avail = 1'b0;
  logic        rx_ack;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        active;

  uart_wb_bridge #(.wb_timeout(16), .rx_timeout(100)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .active(active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  txlog[$];
  logic [31:0] log_adr[$], log_dat[$];
  logic        log_we[$];
  logic [3:0]  log_sel[$];
  logic [31:0] mem [logic [31:0]];
  int ack_delay = 3;
  bit rand_delay = 1'b0;
  int cur_delay = 0, cur_len = 0, last_len = 0, cyc_starts = 0;
  int consec = 0, busy_viol = 0, busy_cnt = 0;
  logic prev_cyc = 1'b0, prev_rx_ack = 1'b0;
  logic [7:0] popped;

  // uart rx/tx and wishbone slave models, all sampled away from the active edge
  always @(negedge clk) begin
    if (rx_ack) begin
      if (rxq.size() > 0) popped = rxq.pop_front();
      if (prev_rx_ack) consec++;
    end
    prev_rx_ack = rx_ack;
    rx_avail = (rxq.size() != 0);
    rx_data  = rx_avail ? rxq[0] : 8'h00;

    if (tx_wr) begin
      txlog.push_back(tx_data);
      if (tx_busy) busy_viol++;
      busy_cnt = $urandom_range(6, 2);
    end
    tx_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;

    wb_ack_i = 1'b0;
    if (wb_cyc_o && wb_stb_o) begin
      if (!prev_cyc) begin
        cyc_starts++;
        cur_len = 0;
        cur_delay = rand_delay ? int'($urandom_range(6, 1)) : ack_delay;
      end
      cur_len++;
      if (cur_len == cur_delay) begin
        wb_ack_i = 1'b1;
        wb_dat_i = mem.exists(wb_adr_o) ? mem[wb_adr_o] : ~wb_adr_o;
        if (wb_we_o) mem[wb_adr_o] = wb_dat_o;
        log_adr.push_back(wb_adr_o);
        log_dat.push_back(wb_we_o ? wb_dat_o : wb_dat_i);
        log_we.push_back(wb_we_o);
        log_sel.push_back(wb_sel_o);
      end
    end else if (prev_cyc) begin
      last_len = cur_len;
    end
    prev_cyc = wb_cyc_o && wb_stb_o;
  end

  task automatic push32(input logic [31:0] v);
    for (int i = 3; i >= 0; i--) rxq.push_back(v[i*8 +: 8]);
  endtask

  task automatic send_read(input logic [31:0] a);
    rxq.push_back(8'h72);
    push32(a);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    rxq.push_back(8'h77);
    push32(a);
    push32(d);
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((rxq.size() != 0 || active || tx_busy) && n < max_cycles);
    total++;
    if (n >= max_cycles) begin
      bad++;
      $display("FAIL %s_idle: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic test_reset();
    total++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'h0) begin bad++; $display("FAIL reset_wb_ctl: got %b want 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
    total++; if ({rx_ack, tx_wr, active} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {rx_ack, tx_wr, active}); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    total++; if (wb_adr_o !== 32'h0) begin bad++; $display("FAIL reset_adr: got %h want 0", wb_adr_o); end
    total++; if (wb_dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat: got %h want 0", wb_dat_o); end
  endtask

  task automatic test_write();
    int s0 = cyc_starts;
    int l0 = log_adr.size();
    int t0 = txlog.size();
    ack_delay = 3;
    send_write(32'h0000_1000, 32'hDEAD_BEEF);
    wait_idle(500, "write");
    total++; if (cyc_starts - s0 !== 1) begin bad++; $display("FAIL write_cycles: got %0d want 1", cyc_starts - s0); end
    total++; if (log_adr[l0] !== 32'h0000_1000) begin bad++; $display("FAIL write_adr: got %h want 00001000", log_adr[l0]); end
    total++; if (log_dat[l0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL write_dat: got %h want deadbeef", log_dat[l0]); end
    total++; if ({log_we[l0], log_sel[l0]} !== 5'b1_1111) begin bad++; $display("FAIL write_we_sel: got %b want 11111", {log_we[l0], log_sel[l0]}); end
    total++; if (last_len !== 3) begin bad++; $display("FAIL write_cyc_len: got %0d want 3", last_len); end
    total++; if (txlog.size() - t0 !== 1 || txlog[t0] !== 8'h4B) begin bad++; $display("FAIL write_resp: got %0d bytes first %h want 1 byte 4b", txlog.size() - t0, txlog[t0]); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL write_active: got %b want 0", active); end
  endtask

  task automatic test_read();
    int l0 = log_adr.size();
    int t0 = txlog.size();
    logic [31:0] got;
    mem[32'h0000_1000] = 32'h1234_5678;
    send_read(32'h0000_1000);
    wait_idle(500, "read");
    total++; if ({log_adr[l0], log_we[l0]} !== {32'h0000_1000, 1'b0}) begin bad++; $display("FAIL read_adr_we: got %h/%b want 00001000/0", log_adr[l0], log_we[l0]); end
    got = {txlog[t0], txlog[t0+1], txlog[t0+2], txlog[t0+3]};
    total++; if (txlog.size() - t0 !== 4 || got !== 32'h1234_5678) begin bad++; $display("FAIL read_resp: got %0d bytes %h want 4 bytes 12345678", txlog.size() - t0, got); end
    total++; if (busy_viol !== 0) begin bad++; $display("FAIL read_tx_busy: got %0d writes while busy want 0", busy_viol); end
  endtask

  task automatic test_bus_timeout();
    int s0 = cyc_starts;
    int l0 = log_adr.size();
    int t0 = txlog.size();
    logic [31:0] got;
    ack_delay = 0;
    send_read(32'h0000_2000);
    wait_idle(500, "bus_to");
    total++; if (last_len !== 16) begin bad++; $display("FAIL bus_to_len: got %0d want 16", last_len); end
    total++; if (txlog.size() - t0 !== 1 || txlog[t0] !== 8'h45) begin bad++; $display("FAIL bus_to_resp: got %0d bytes first %h want 1 byte 45", txlog.size() - t0, txlog[t0]); end
    total++; if (log_adr.size() !== l0 || cyc_starts - s0 !== 1) begin bad++; $display("FAIL bus_to_cycles: got acks %0d cycles %0d want 0/1", log_adr.size() - l0, cyc_starts - s0); end
    ack_delay = 16;
    t0 = txlog.size();
    send_read(32'h0000_1000);
    wait_idle(500, "bus_edge");
    got = {txlog[t0], txlog[t0+1], txlog[t0+2], txlog[t0+3]};
    total++; if (txlog.size() - t0 !== 4 || got !== 32'h1234_5678) begin bad++; $display("FAIL bus_edge_resp: got %0d bytes %h want 4 bytes 12345678", txlog.size() - t0, got); end
    total++; if (last_len !== 16) begin bad++; $display("FAIL bus_edge_len: got %0d want 16", last_len); end
  endtask

  task automatic test_rx_timeout();
    int s0 = cyc_starts;
    int l0 = log_adr.size();
    int t0 = txlog.size();
    logic [31:0] got;
    ack_delay = 2;
    rxq.push_back(8'h72); rxq.push_back(8'h00); rxq.push_back(8'h00);
    repeat (200) @(negedge clk);
    total++; if (active !== 1'b0 || cyc_starts !== s0) begin bad++; $display("FAIL rx_to_discard: got active %b cycles %0d want 0/0", active, cyc_starts - s0); end
    send_read(32'h0000_0004);
    wait_idle(500, "rx_to");
    got = {txlog[t0], txlog[t0+1], txlog[t0+2], txlog[t0+3]};
    total++; if (log_adr.size() - l0 !== 1 || log_adr[l0] !== 32'h4) begin bad++; $display("FAIL rx_to_adr: got %0d acks adr %h want 1 adr 00000004", log_adr.size() - l0, log_adr[l0]); end
    total++; if (got !== 32'hFFFF_FFFB) begin bad++; $display("FAIL rx_to_resp: got %h want fffffffb", got); end
  endtask

  task automatic test_junk_back_to_back();
    int s0 = cyc_starts;
    int l0 = log_adr.size();
    int t0 = txlog.size();
    rxq.push_back(8'h67); rxq.push_back(8'h00); rxq.push_back(8'h00);
    send_write(32'h0000_0008, 32'hCAFE_F00D);
    wait_idle(500, "junk");
    total++; if (cyc_starts - s0 !== 1 || {log_adr[l0], log_dat[l0]} !== {32'h8, 32'hCAFE_F00D}) begin bad++; $display("FAIL junk_write: got cycles %0d adr %h dat %h want 1/00000008/cafef00d", cyc_starts - s0, log_adr[l0], log_dat[l0]); end
    total++; if (txlog.size() - t0 !== 1 || txlog[t0] !== 8'h4B) begin bad++; $display("FAIL junk_resp: got %0d bytes first %h want 1 byte 4b", txlog.size() - t0, txlog[t0]); end
    total++; if (consec !== 0) begin bad++; $display("FAIL rx_ack_consecutive: got %0d want 0", consec); end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_adr[$], exp_dat[$];
    logic        exp_we[$];
    logic [7:0]  exp_tx[$];
    int l0 = log_adr.size();
    int t0 = txlog.size();
    mem.delete();
    rand_delay = 1'b1;
    for (int i = 0; i < 25; i++) begin
      int kind = $urandom_range(2, 0);
      logic [31:0] a = 32'h8000_0000 | (32'($urandom_range(7, 0)) << 2);
      logic [31:0] d = $urandom;
      logic [7:0]  j = 8'($urandom_range(255, 0));
      if (kind == 0) begin
        if (j == 8'h72 || j == 8'h77) j = 8'h00;
        rxq.push_back(j);
      end else if (kind == 1) begin
        d = ref_mem.exists(a) ? ref_mem[a] : ~a;
        exp_adr.push_back(a); exp_dat.push_back(d); exp_we.push_back(1'b0);
        for (int k = 3; k >= 0; k--) exp_tx.push_back(d[k*8 +: 8]);
        send_read(a);
      end else begin
        ref_mem[a] = d;
        exp_adr.push_back(a); exp_dat.push_back(d); exp_we.push_back(1'b1);
        exp_tx.push_back(8'h4B);
        send_write(a, d);
      end
    end
    wait_idle(8000, "random");
    rand_delay = 1'b0;
    total++; if (log_adr.size() - l0 !== exp_adr.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", log_adr.size() - l0, exp_adr.size()); end
    for (int i = 0; i < exp_adr.size(); i++) begin
      total++;
      if ({log_adr[l0+i], log_dat[l0+i], log_we[l0+i]} !== {exp_adr[i], exp_dat[i], exp_we[i]}) begin
        bad++; $display("FAIL rand_txn%0d: got %h/%h/%b want %h/%h/%b", i, log_adr[l0+i], log_dat[l0+i], log_we[l0+i], exp_adr[i], exp_dat[i], exp_we[i]);
      end
    end
    total++; if (txlog.size() - t0 !== exp_tx.size()) begin bad++; $display("FAIL rand_tx_count: got %0d want %0d", txlog.size() - t0, exp_tx.size()); end
    for (int i = 0; i < exp_tx.size(); i++) begin
      total++;
      if (txlog[t0+i] !== exp_tx[i]) begin bad++; $display("FAIL rand_tx%0d: got %h want %h", i, txlog[t0+i], exp_tx[i]); end
    end
    total++; if (consec !== 0 || busy_viol !== 0) begin bad++; $display("FAIL rand_handshake: got consec %0d busy %0d want 0/0", consec, busy_viol); end
  endtask

  task automatic test_reset_mid();
    int t0 = txlog.size();
    int n = 0;
    int s1;
    ack_delay = 0;
    send_read(32'h0000_0040);
    while (!wb_cyc_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++; if (wb_cyc_o !== 1'b1) begin bad++; $display("FAIL rst_mid_start: got cyc %b want 1", wb_cyc_o); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if ({wb_cyc_o, wb_stb_o, tx_wr, active} !== 4'b0000) begin bad++; $display("FAIL rst_mid_drop: got %b want 0000", {wb_cyc_o, wb_stb_o, tx_wr, active}); end
    reset = 1'b1;
    s1 = cyc_starts;
    repeat (60) @(negedge clk);
    total++; if (txlog.size() !== t0 || cyc_starts !== s1) begin bad++; $display("FAIL rst_mid_silent: got %0d bytes %0d cycles want 0/0", txlog.size() - t0, cyc_starts - s1); end
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_write();
    test_read();
    test_bus_timeout();
    test_rx_timeout();
    test_junk_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/uart_wb_bridge.md
Name: uart_wb_bridge

Overview:
- Byte-stream debug bridge between the SoC's UART receiver/transmitter and the Wishbone bus.
- Consumes command bytes from the uart rx interface, decodes read/write commands with 32-bit address and data, and runs single Wishbone master transactions.
- Returns results and status bytes through the uart tx interface.
- Placed in system next to the uart instance; acts as a second bus master for host-side memory inspection and program loading.

Parameters:
- wb_timeout, 1024, clock cycles to wait for wb_ack_i before aborting a bus cycle.
- rx_timeout, 1000000, idle clock cycles allowed between bytes of one command before the command is discarded.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- rx_data  in  8  received byte from uart
- rx_avail  in  1  byte available from uart
- rx_ack  out  1  one-cycle pulse consuming rx_data
- tx_data  out  8  byte to transmit
- tx_wr  out  1  one-cycle pulse starting transmission
- tx_busy  in  1  uart transmitter busy
- wb_adr_o  out  32  bus address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  byte selects, always 4'b1111 during a cycle
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  bus acknowledge
- active  out  1  high while a command is being processed (state != IDLE)

Behaviour:
- Reset (reset==0 at posedge clk): state=IDLE, all outputs 0, address/data/count registers 0. Reset mid-transaction drops cyc/stb the next edge; a pending tx byte is not sent.
- Byte consumption: a byte is taken when rx_avail && !rx_ack. rx_ack is asserted for exactly one cycle per byte taken, and is never asserted on two consecutive cycles.
- Commands, multi-byte fields MSB first:
  - 'r' (0x72) followed by A3..A0: read.
  - 'w' (0x77) followed by A3..A0 and D3..D0: write.
  - Any other byte in IDLE is consumed and ignored, with no response.
- States: IDLE -> ADDR (4 bytes, 2-bit counter) -> DATA (write only, 4 bytes) -> BUS -> TX -> TX_WAIT -> back to TX or to IDLE.
- Timeout in ADDR/DATA: an idle counter restarts on every byte taken. When it reaches rx_timeout, return to IDLE with no bus access and no response.
- BUS state:
  - cyc=stb=1, sel=1111, we=1 for writes; adr and dat held stable.
  - On wb_ack_i, cyc/stb drop on the next edge and wb_dat_i is latched that same edge (reads).
  - If wb_ack_i is absent for wb_timeout cycles after cyc rises, abort: drop cyc/stb and set the error flag.
  - wb_ack_i arriving in the same cycle the timeout expires counts as success.
- Responses:
  - Write OK: 0x4B ('K').
  - Read OK: 4 bytes, data MSB first.
  - Either timeout: single 0x45 ('E').
- TX handshake:
  - In TX with tx_busy==0, drive tx_data and pulse tx_wr for one cycle.
  - TX_WAIT holds one guard cycle, then waits for tx_busy==0 before the next byte or before IDLE.
  - tx_data holds its value until the next tx_wr.
- Bytes arriving during BUS/TX are not acknowledged; they stay pending in the uart and are taken after returning to IDLE.
- Minimum command latency: the last rx byte taken -> cyc rises on the next cycle.

Test Plan:
- Write: send 77 00 00 10 00 DE AD BE EF, slave acks after 3 cycles -> one WB cycle adr=0x00001000, dat_o=0xDEADBEEF, we=1, sel=F; tx byte 0x4B; active returns to 0.
- Read: send 72 00 00 10 00, slave returns 0x12345678 -> WB read adr=0x00001000, we=0; tx bytes 12,34,56,78 in order, each tx_wr issued only when tx_busy==0.
- Bus timeout (wb_timeout=16 in bench): read to a non-acking slave -> cyc high exactly 16 cycles, then drops; tx single 0x45; a following valid read succeeds.
- Rx timeout (rx_timeout=100): send 72 00 00, then idle 200 cycles, then 72 00 00 00 04 -> first command discarded with no bus cycle; second reads adr=0x00000004.
- Junk and back-to-back: send 67 00 00 then a write command immediately after -> 67/00/00 acked and ignored with no tx; the write executes normally; rx_ack is never high on two consecutive cycles.
- Reset mid-cycle: assert reset (0) while cyc=1 -> cyc/stb/tx_wr are 0 at the next edge; state is IDLE; no response byte is sent after release.
